washing_actuator_drv: RTL and testbench

//  Downstream of the washing machine FSM: consumes its stage[2:0] and supply and drives the

---
 rtl/wm_pkg.sv | 32 +++
 rtl/wm_agitator.sv | 72 +++++++
 rtl/washing_actuator_drv.sv | 121 ++++++++++++
 tb/tb_washing_actuator_drv.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine actuator driver: stage codes,
// agitator state encoding and stage classification helpers.
package wm_pkg;

  typedef logic [2:0] stage_t;

  localparam stage_t ST_IDLE    = 3'd0;
  localparam stage_t ST_FILL    = 3'd1;
  localparam stage_t ST_WASH    = 3'd2;
  localparam stage_t ST_RINSE   = 3'd3;
  localparam stage_t ST_SPIN    = 3'd4;
  localparam stage_t ST_DRAIN   = 3'd5;
  localparam stage_t ST_DONE    = 3'd6;
  localparam stage_t ST_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    AG_IDLE,
    AG_FWD,
    AG_P1,
    AG_REV,
    AG_P2
  } ag_state_t;

  function automatic logic is_agit(input stage_t s);
    return (s == ST_WASH) || (s == ST_RINSE);
  endfunction

  function automatic logic is_active(input stage_t s);
    return (s >= ST_FILL) && (s <= ST_DRAIN);
  endfunction

endpackage

// File: rtl/wm_agitator.sv
// Agitation pattern generator: forward / pause / reverse / pause with a
// per-phase timer. hold freezes the pattern; run=0 parks it in AG_IDLE.
module wm_agitator #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned AGIT_ON    = 20,
  parameter int unsigned AGIT_PAUSE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  input  logic hold,
  output logic motor_en,
  output logic motor_dir
);
  import wm_pkg::*;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(AGIT_ON - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(AGIT_PAUSE - 1);

  ag_state_t        state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] last;
  logic             en_nxt;
  logic             dir_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= AG_IDLE;
      timer     <= '0;
      motor_en  <= 1'b0;
      motor_dir <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      motor_en  <= en_nxt;
      motor_dir <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    last      = ((state == AG_P1) || (state == AG_P2)) ? PAUSE_LAST : ON_LAST;

    if (!run) begin
      state_nxt = AG_IDLE;
      timer_nxt = '0;
    end else if (restart || (state == AG_IDLE)) begin
      state_nxt = AG_FWD;
      timer_nxt = '0;
    end else if (!hold) begin
      // Timer only advances below the phase limit, so it can never wrap.
      if (timer >= last) begin
        timer_nxt = '0;
        unique case (state)
          AG_FWD:  state_nxt = AG_P1;
          AG_P1:   state_nxt = AG_REV;
          AG_REV:  state_nxt = AG_P2;
          AG_P2:   state_nxt = AG_FWD;
          default: state_nxt = AG_FWD;
        endcase
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end

    en_nxt  = !hold && ((state_nxt == AG_FWD) || (state_nxt == AG_REV));
    dir_nxt = hold ? motor_dir : (state_nxt == AG_REV);
  end

endmodule

// File: rtl/washing_actuator_drv.sv
// Actuator driver behind the washing-machine FSM: maps stage/supply onto valve,
// pump, motor, door lock and buzzer. Buzzer built only with WM_BUZZER_EN defined.
module washing_actuator_drv #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned AGIT_ON     = 20,
  parameter int unsigned AGIT_PAUSE  = 5,
  parameter int unsigned LOCK_HOLD   = 30,
  parameter int unsigned BEEP_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] stage,
  input  logic       supply,
  output logic       water_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       buzzer,
  output logic       fault
);
  import wm_pkg::*;

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_HOLD);

  stage_t           prev_stage;
  logic [CNT_W-1:0] lock_cnt;
  logic             fault_nxt;
  logic             live;
  logic             run;
  logic             restart;
  logic             hold;
  logic             ag_en;

  always_comb begin
    fault_nxt = fault ? (stage != ST_IDLE) : (stage == ST_ILLEGAL);
    live      = supply && !fault_nxt;
    run       = is_agit(stage) && !fault_nxt;
    restart   = is_agit(stage) && (stage != prev_stage);
    hold      = !supply;
  end

  wm_agitator #(
    .CNT_W      (CNT_W),
    .AGIT_ON    (AGIT_ON),
    .AGIT_PAUSE (AGIT_PAUSE)
  ) u_agitator (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .restart   (restart),
    .hold      (hold),
    .motor_en  (ag_en),
    .motor_dir (motor_dir)
  );

  // Spin drive and agitation never overlap; both terms are flops.
  assign motor_en = ag_en | motor_fast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault       <= 1'b0;
      prev_stage  <= ST_IDLE;
      water_valve <= 1'b0;
      drain_pump  <= 1'b0;
      motor_fast  <= 1'b0;
      door_lock   <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      fault       <= fault_nxt;
      water_valve <= live && (stage == ST_FILL);
      drain_pump  <= live && ((stage == ST_SPIN) || (stage == ST_DRAIN));
      motor_fast  <= live && (stage == ST_SPIN);
      if (supply) begin
        prev_stage <= stage;
        // Lock counter is preloaded while locked-active so any exit starts a full hold.
        if (fault_nxt || is_active(stage)) begin
          door_lock <= 1'b1;
          lock_cnt  <= LOCK_LOAD;
        end else if (lock_cnt != '0) begin
          door_lock <= 1'b1;
          lock_cnt  <= lock_cnt - 1'b1;
        end else begin
          door_lock <= 1'b0;
        end
      end
    end
  end

`ifdef WM_BUZZER_EN
  localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_CYCLES - 1);

  logic [CNT_W-1:0] beep_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzzer   <= 1'b0;
      beep_cnt <= '0;
    end else if (!supply) begin
      buzzer <= 1'b0;
    end else if (fault_nxt || (stage != ST_DONE)) begin
      buzzer   <= 1'b0;
      beep_cnt <= '0;
    end else if (prev_stage != ST_DONE) begin
      buzzer   <= 1'b1;
      beep_cnt <= BEEP_LOAD;
    end else if (beep_cnt != '0) begin
      buzzer   <= 1'b1;
      beep_cnt <= beep_cnt - 1'b1;
    end else begin
      buzzer <= 1'b0;
    end
  end
`else
  // Parameter kept so instantiations stay identical with the beep compiled out.
  localparam int unsigned beep_cycles_unused = BEEP_CYCLES;
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_washing_actuator_drv.sv
// Scoreboard bench for washing_actuator_drv: random stage/supply segments are
// scored against a phase/elapsed-time reference model of the actuator rules.
module tb_washing_actuator_drv;

  localparam int CNT_W       = 8;
  localparam int AGIT_ON     = 20;
  localparam int AGIT_PAUSE  = 5;
  localparam int LOCK_HOLD   = 30;
  localparam int BEEP_CYCLES = 10;
  localparam int PERIOD      = 2 * (AGIT_ON + AGIT_PAUSE);
  localparam int BIG         = 1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] stage = 3'd0;
  logic       supply = 1'b0;
  logic       water_valve, drain_pump, motor_en, motor_dir;
  logic       motor_fast, door_lock, buzzer, fault;

  always #5 clk = ~clk;

  washing_actuator_drv #(
    .CNT_W       (CNT_W),
    .AGIT_ON     (AGIT_ON),
    .AGIT_PAUSE  (AGIT_PAUSE),
    .LOCK_HOLD   (LOCK_HOLD),
    .BEEP_CYCLES (BEEP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stage       (stage),
    .supply      (supply),
    .water_valve (water_valve),
    .drain_pump  (drain_pump),
    .motor_en    (motor_en),
    .motor_dir   (motor_dir),
    .motor_fast  (motor_fast),
    .door_lock   (door_lock),
    .buzzer      (buzzer),
    .fault       (fault)
  );

  typedef struct {
    time        due;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, expressed in elapsed-cycle terms.
  bit m_fault, m_lock, m_dir;
  int m_prev, m_phase, m_since, m_beep;

  function automatic logic [7:0] outs();
    return {fault, buzzer, door_lock, motor_fast, motor_dir, motor_en, drain_pump, water_valve};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b (fault,buzz,lock,fast,dir,en,pump,valve)",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fault = 0; m_lock = 0; m_dir = 0;
    m_prev  = 0; m_phase = -1; m_since = BIG; m_beep = BIG;
  endtask

  task automatic model_step(input int s, input bit sup, output logic [7:0] e);
    bit f, agit, in_fwd, in_rev, en, valve, pump, fast, buzz;
    f    = m_fault ? (s != 0) : (s == 7);
    agit = (s == 2 || s == 3) && !f;
    if (!agit)                          m_phase = -1;
    else if (s != m_prev || m_phase < 0) m_phase = 0;
    else if (sup)                       m_phase = (m_phase + 1) % PERIOD;
    in_fwd = (m_phase >= 0) && (m_phase < AGIT_ON);
    in_rev = (m_phase >= AGIT_ON + AGIT_PAUSE) && (m_phase < 2 * AGIT_ON + AGIT_PAUSE);
    en     = sup && (in_fwd || in_rev);
    if (sup) m_dir = in_rev;
    valve = sup && !f && (s == 1);
    pump  = sup && !f && (s == 4 || s == 5);
    fast  = sup && !f && (s == 4);
    if (sup) begin
      if (f || (s >= 1 && s <= 5)) m_since = 0;
      else if (m_since < BIG)      m_since++;
      m_lock = (m_since <= LOCK_HOLD);
    end
    buzz = 0;
    if (sup) begin
      if (f || s != 6) m_beep = BIG;
      else begin
        if (m_prev != 6)       m_beep = 1;
        else if (m_beep < BIG) m_beep++;
        buzz = (m_beep <= BEEP_CYCLES);
      end
    end
`ifndef WM_BUZZER_EN
    buzz = 0;
`endif
    if (sup) m_prev = s;
    m_fault = f;
    e = {f, buzz, m_lock, fast, m_dir, en | fast, pump, valve};
  endtask

  task automatic drive(input int s, input bit sup);
    logic [7:0] e;
    @(posedge clk);
    #1;
    stage  = 3'(s);
    supply = sup;
    model_step(s, sup, e);
    sb.push_back('{due: $time + 9, exp: e});
  endtask

  task automatic seg(input int s, input bit sup, input int n);
    for (int i = 0; i < n; i++) drive(s, sup);
  endtask

  // Monitor: one scored output word per clock edge, decoupled from the driver.
  initial begin
    time  t_edge;
    exp_t it;
    forever begin
      @(posedge clk);
      #2;
      t_edge = $time - 2;
      if (!rst) begin
        while (sb.size() != 0 && sb[0].due <= t_edge) begin
          it = sb.pop_front();
          if (it.due != t_edge) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale_entry at %0t: entry due %0t, edge %0t", $time, it.due, t_edge);
          end else begin
            check("outputs", outs(), it.exp);
            check("valve_pump_excl", {7'd0, water_valve & drain_pump}, 8'd0);
            check("fast_dir_excl", {7'd0, motor_fast & motor_dir}, 8'd0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int s, len, off, dl;
    bit drop;
    model_reset();
    #1 rst = 1'b1;
    #2 check("reset_state", outs(), 8'd0);
    #20 rst = 1'b0;

    seg(1, 1, 3);
    seg(2, 1, 60);
    seg(0, 1, 5);
    seg(2, 1, 10);
    seg(2, 0, 30);
    seg(2, 1, 15);
    seg(5, 1, 4);
    seg(0, 1, 40);
    seg(5, 1, 3);
    seg(0, 1, 15);
    seg(1, 1, 3);
    seg(0, 1, 35);
    seg(4, 1, 5);
    seg(6, 1, 15);
    seg(4, 1, 3);
    seg(7, 1, 2);
    seg(4, 1, 2);
    seg(2, 1, 5);
    seg(0, 1, 35);
    seg(3, 1, 30);
    seg(2, 1, 10);
    seg(6, 1, 4);
    seg(0, 1, 3);
    seg(4, 1, 6);

    // Asynchronous reset mid-cycle while spinning.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset", outs(), 8'd0);
    stage  = 3'd0;
    supply = 1'b0;
    #10 rst = 1'b0;
    model_reset();

    for (int k = 0; k < 150; k++) begin
      s    = ($urandom_range(0, 99) < 6) ? 7 : int'($urandom_range(0, 6));
      len  = $urandom_range(1, 70);
      drop = ($urandom_range(0, 99) < 20);
      off  = $urandom_range(0, len - 1);
      dl   = $urandom_range(1, 25);
      for (int i = 0; i < len; i++)
        drive(s, !(drop && i >= off && i < off + dl));
    end

    repeat (3) @(posedge clk);
    #5;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover_entries: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
